// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay bank scheduler.
package relay_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ON   = 2'd2
    } ch_state_t;

    // Bits needed to hold a count in 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/relay_channel.sv
// One relay channel: IDLE/PEND/ON state machine with a retriggerable hold timer.
module relay_channel
    import relay_pkg::*;
#(
    parameter logic [TIMER_W-1:0] ON_CYCLES = 32'd100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_enable,
    input  logic i_req,
    input  logic i_grant,
    output logic o_pending,
    output logic o_active,
    output logic o_relay_n,
    output logic o_act_nxt,
    output logic o_pend_nxt
);

    ch_state_t          r_state;
    ch_state_t          w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               r_pending;
    logic               r_active;
    logic               r_relay_n;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                IDLE: if (i_req) w_state_nxt = PEND;
                // Requests are latched: a PEND channel waits here even if req drops.
                PEND: if (i_grant) begin
                    w_state_nxt = ON;
                    w_timer_nxt = ON_CYCLES;
                end
                ON: begin
                    if (i_req) begin
                        w_timer_nxt = ON_CYCLES;
                    end else if (r_timer == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_timer_nxt = r_timer - TIMER_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    assign o_act_nxt  = (w_state_nxt == ON);
    assign o_pend_nxt = (w_state_nxt == PEND);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_active  <= 1'b0;
            r_relay_n <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= o_pend_nxt;
            r_active  <= o_act_nxt;
            r_relay_n <= ~o_act_nxt;
        end
    end

    assign o_pending = r_pending;
    assign o_active  = r_active;
    assign o_relay_n = r_relay_n;

endmodule

// File: rtl/relay_bank_scheduler.sv
// Shares MAX_ON relay slots among N_CH channels with round-robin grants
// spaced by a stagger interval to limit inrush current.
module relay_bank_scheduler
    import relay_pkg::*;
#(
    parameter int unsigned        N_CH           = 4,
    parameter int unsigned        MAX_ON         = 2,
    parameter logic [TIMER_W-1:0] ON_CYCLES      = 32'd100_000_000,
    parameter logic [TIMER_W-1:0] STAGGER_CYCLES = 32'd5_000_000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [N_CH-1:0]           req,
    output logic [N_CH-1:0]           relay_n,
    output logic [N_CH-1:0]           active_mask,
    output logic [N_CH-1:0]           pending_mask,
    output logic [cnt_w(N_CH)-1:0]    active_count,
    output logic                      busy
);

    localparam int CNT_W = cnt_w(N_CH);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [TIMER_W-1:0] r_stagger;
    logic [CNT_W-1:0]   r_active_count;
    logic               r_busy;

    logic [N_CH-1:0]    w_grant;
    logic [N_CH-1:0]    w_act_nxt;
    logic [N_CH-1:0]    w_pend_nxt;
    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_rr_nxt;
    logic               w_found;
    logic               w_slot_ok;
    logic [CNT_W-1:0]   w_cnt_nxt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        relay_channel #(
            .ON_CYCLES (ON_CYCLES)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_enable   (enable),
            .i_req      (req[g]),
            .i_grant    (w_grant[g]),
            .o_pending  (pending_mask[g]),
            .o_active   (active_mask[g]),
            .o_relay_n  (relay_n[g]),
            .o_act_nxt  (w_act_nxt[g]),
            .o_pend_nxt (w_pend_nxt[g])
        );
    end

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N_CH)) w_sum = w_sum - (PTR_W+1)'(N_CH);
            if (!w_found && pending_mask[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PTR_W-1:0];
            end
        end
    end

    // The registered count is used, so a slot freed this edge is only reusable next cycle.
    assign w_slot_ok = enable && (r_active_count < CNT_W'(MAX_ON)) && (r_stagger == '0);
    assign w_rr_nxt  = (w_win == PTR_W'(N_CH - 1)) ? '0 : w_win + PTR_W'(1);

    always_comb begin
        w_grant = '0;
        if (w_slot_ok && w_found) w_grant[w_win] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < N_CH; i++) w_cnt_nxt = w_cnt_nxt + CNT_W'(w_act_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr       <= '0;
            r_stagger      <= '0;
            r_active_count <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_active_count <= w_cnt_nxt;
            r_busy         <= |{w_act_nxt, w_pend_nxt};
            if (!enable) begin
                r_stagger <= '0;
            end else if (w_grant != '0) begin
                r_stagger <= STAGGER_CYCLES;
                r_rr_ptr  <= w_rr_nxt;
            end else if (r_stagger != '0) begin
                r_stagger <= r_stagger - TIMER_W'(1);
            end
        end
    end

    assign active_count = r_active_count;
    assign busy         = r_busy;

endmodule

// File: tb/tb_relay_bank_scheduler.sv
// Scoreboard bench: a deadline-based reference model predicts every cycle's outputs.
module tb_relay_bank_scheduler;

    localparam int N     = 4;
    localparam int MAXON = 2;
    localparam int ONC   = 10;
    localparam int STG   = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] relay_n;
    logic [3:0] active_mask;
    logic [3:0] pending_mask;
    logic [2:0] active_count;
    logic       busy;

    always #5 clk = ~clk;

    relay_bank_scheduler #(
        .N_CH           (N),
        .MAX_ON         (MAXON),
        .ON_CYCLES      (32'd10),
        .STAGGER_CYCLES (32'd3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .req          (req),
        .relay_n      (relay_n),
        .active_mask  (active_mask),
        .pending_mask (pending_mask),
        .active_count (active_count),
        .busy         (busy)
    );

    typedef struct packed {
        logic [3:0] relay_n;
        logic [3:0] act;
        logic [3:0] pend;
        logic [2:0] cnt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: 0 idle, 1 waiting, 2 energised; an energised channel drops once the
    // current edge is more than ONC edges past its last refresh (grant or request).
    int ms[N];
    int refresh[N];
    int last_grant;
    int rr;
    int ncyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, ncyc, act, expv);
        end
    endtask

    task automatic model_step(input logic rn, input logic en, input logic [3:0] r);
        int   cnt_pre;
        int   win;
        int   c;
        exp_t e;
        ncyc++;
        if (!rn || !en) begin
            for (int i = 0; i < N; i++) ms[i] = 0;
            last_grant = -1000;
            if (!rn) rr = 0;
        end else begin
            cnt_pre = 0;
            for (int i = 0; i < N; i++) if (ms[i] == 2) cnt_pre++;
            win = -1;
            if (cnt_pre < MAXON && (ncyc - last_grant) > STG) begin
                for (int k = 0; k < N; k++) begin
                    c = (rr + k) % N;
                    if (win < 0 && ms[c] == 1) win = c;
                end
            end
            for (int i = 0; i < N; i++) begin
                case (ms[i])
                    0: if (r[i]) ms[i] = 1;
                    1: if (i == win) begin ms[i] = 2; refresh[i] = ncyc; end
                    default: begin
                        if (r[i]) refresh[i] = ncyc;
                        else if (ncyc > refresh[i] + ONC) ms[i] = 0;
                    end
                endcase
            end
            if (win >= 0) begin
                rr = (win + 1) % N;
                last_grant = ncyc;
            end
        end
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.act[i]     = (ms[i] == 2);
            e.pend[i]    = (ms[i] == 1);
            e.relay_n[i] = (ms[i] != 2);
            if (ms[i] == 2) e.cnt = e.cnt + 3'd1;
        end
        e.busy = |{e.act, e.pend};
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rn, input logic en, input logic [3:0] r);
        reset_n = rn;
        enable  = en;
        req     = r;
        @(posedge clk);
        model_step(rn, en, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 4'b0000);
    endtask

    // Monitor: one expected response per clock edge, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("relay_n", int'(relay_n), int'(e.relay_n));
                chk("active_mask", int'(active_mask), int'(e.act));
                chk("pending_mask", int'(pending_mask), int'(e.pend));
                chk("active_count", int'(active_count), int'(e.cnt));
                chk("busy", int'(busy), int'(e.busy));
                chk("count_eq_popcount", int'(active_count), $countones(active_mask));
                chk("max_on_respected", int'(active_count <= 3'(MAXON)), 1);
            end
        end
    end

    initial begin
        logic [3:0] r;
        logic       en;
        logic       rn;
        for (int i = 0; i < N; i++) begin
            ms[i] = 0;
            refresh[i] = 0;
        end
        last_grant = -1000;
        rr = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        req     = 4'b0000;

        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0000);

        // single one-cycle pulse
        step(1'b1, 1'b1, 4'b0001);
        idle(16);

        // contention: all four at once
        step(1'b1, 1'b1, 4'b1111);
        idle(45);

        // retrigger: hold channel 1 across its grant and beyond
        for (int i = 0; i < 22; i++) step(1'b1, 1'b1, 4'b0010);
        idle(16);

        // fairness: ch3 granted last, then ch0 and ch3 compete
        step(1'b1, 1'b1, 4'b1000);
        idle(16);
        step(1'b1, 1'b1, 4'b1001);
        idle(30);

        // enable drop with two on and one pending; pulses while disabled are ignored
        step(1'b1, 1'b1, 4'b0111);
        idle(6);
        step(1'b1, 1'b0, 4'b1111);
        idle(16);

        // reset mid-activity, requests present during reset
        step(1'b1, 1'b1, 4'b1111);
        idle(8);
        step(1'b0, 1'b1, 4'b1111);
        step(1'b0, 1'b1, 4'b1111);
        idle(40);

        for (int c = 0; c < 1500; c++) begin
            r = '0;
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) r[b] = 1'b1;
            en = ($urandom_range(0, 49) != 0);
            rn = ($urandom_range(0, 199) != 0);
            step(rn, en, r);
        end
        idle(30);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
